alu_op_sequencer: RTL and testbench
===================================

Name: alu_op_sequencer

Overview:
Upstream control stage for the ArithmeticLogicUnit. It accepts one operation per handshake and reads both operands from the register file over a single read port. It then drives the ALU's operand buses and one-hot control lines, captures the result, and writes it back to the register file. Fixed-latency, non-pipelined FSM that also maintains the zero and carry status flags.

Parameters:
DATA_WIDTH, 8, operand/result width; matches the ALU DATA_WIDTH.
ADDR_WIDTH, 2, register-file address width (4 registers).

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
op_valid  input  1  operation request
op_ready  output  1  sequencer can accept; high only in IDLE
opcode  input  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 INV, 6 CLR, 7-15 illegal
rs_a  input  ADDR_WIDTH  source A register
rs_b  input  ADDR_WIDTH  source B register
rd  input  ADDR_WIDTH  destination register
rf_raddr  output  ADDR_WIDTH  register-file read address
rf_rdata  input  DATA_WIDTH  register-file read data, combinational on rf_raddr
rf_we  output  1  register-file write enable, one-cycle pulse
rf_waddr  output  ADDR_WIDTH  write address
rf_wdata  output  DATA_WIDTH  write data
alu_in1  output  DATA_WIDTH  to ALU in1
alu_in2  output  DATA_WIDTH  to ALU in2
alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_inv, alu_clr  output  1 each  one-hot ALU controls
alu_out  input  DATA_WIDTH  from ALU out
alu_overflow  input  1  from ALU overflow
done  output  1  one-cycle pulse at completion
err  output  1  high together with done when the opcode was illegal
zero_flag  output  1  last written result == 0
carry_flag  output  1  last written alu_overflow

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. op_ready=1. All other outputs 0, including both flags and the internal opA/opB/result/opcode/rd registers. Deassertion takes effect at the next clk edge.
- States: IDLE -> FETCH_A -> FETCH_B -> EXEC -> WRITE -> IDLE.
- IDLE:
  - op_ready=1.
  - On op_valid=1 at a clock edge, latch opcode, rs_a, rs_b and rd.
  - Legal opcode: go to FETCH_A.
  - Illegal opcode: stay in IDLE and pulse done=1 with err=1 on the next cycle. No rf_we, flags unchanged.
- FETCH_A: rf_raddr=rs_a; latch rf_rdata into opA at the edge.
- FETCH_B: rf_raddr=rs_b; latch rf_rdata into opB at the edge.
- EXEC:
  - alu_in1=opA, alu_in2=opB.
  - Exactly one control line, decoded from opcode, is high.
  - Latch alu_out into result and alu_overflow into carry_next at the edge.
- WRITE:
  - rf_we=1, rf_waddr=rd, rf_wdata=result, done=1, err=0.
  - At the edge: zero_flag <= (result==0), carry_flag <= carry_next.
- All seven ALU control lines are 0 outside EXEC; never more than one is high.
- alu_in1/alu_in2 hold their last values outside EXEC. rf_raddr=0 outside the FETCH states.
- Latency: handshake accepted at edge T; rf_we and done are high in cycle T+4; op_ready returns in cycle T+5. Throughput is one operation per 5 cycles.
- op_ready=0 in all non-IDLE states. op_valid and the operand inputs are ignored while busy.
- rd may equal rs_a or rs_b. Operands are captured before the write, so the old values are used.
- INV and CLR still fetch B; latency stays fixed.
- Flags keep their values across illegal ops and across idle periods.
- Reset mid-operation: immediate return to IDLE. No rf_we is issued for the aborted op, no done pulse, flags cleared.

Test Plan:
- Reset: hold reset=0 for 3 cycles, release -> op_ready=1; rf_we, done, err, all ALU controls and both flags = 0.
- ADD with R1=0x30, R2=0x25, rd=R3 -> alu_add high only in EXEC. At T+4: rf_we=1, rf_waddr=3, rf_wdata=0x55, done=1. zero_flag=0, carry_flag=0.
- SUB with R1=0x05, R2=0x05, rd=R0, then ADD with R1=0xF0, R2=0x20 -> SUB writes 0x00, zero_flag=1. ADD writes 0x10 with carry_flag=1, zero_flag=0.
- AND with R1=0x0C, R2=0x0A, rd=R1 (aliased) -> writes 0x08 to R1. Hold op_valid=1 continuously: the next op is accepted exactly in cycle T+5, not earlier.
- Illegal opcode 9 -> one cycle later done=1, err=1. No rf_we; flags unchanged from the previous op; op_ready stays 1.
- Assert reset=0 during EXEC of an XOR -> immediate IDLE; no rf_we, done or alu_xor afterward. A fresh op after release completes normally.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: fetches two operands, drives the ALU for one cycle, writes the result back and updates flags
module alu_op_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [3:0]            opcode,
  input  logic [ADDR_WIDTH-1:0] rs_a,
  input  logic [ADDR_WIDTH-1:0] rs_b,
  input  logic [ADDR_WIDTH-1:0] rd,
  output logic [ADDR_WIDTH-1:0] rf_raddr,
  input  logic [DATA_WIDTH-1:0] rf_rdata,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  output logic                  alu_add,
  output logic                  alu_sub,
  output logic                  alu_and,
  output logic                  alu_or,
  output logic                  alu_xor,
  output logic                  alu_inv,
  output logic                  alu_clr,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_overflow,
  output logic                  done,
  output logic                  err,
  output logic                  zero_flag,
  output logic                  carry_flag
);
  typedef enum logic [2:0] {IDLE, FETCH_A, FETCH_B, EXEC, WRITE} state_t;
  state_t state, state_next;
  logic [3:0] opc;
  logic [ADDR_WIDTH-1:0] ra, rb, rdq;
  logic [DATA_WIDTH-1:0] opa, opb, in1, result;
  logic carry_next, err_q, legal, exec;
  assign legal = opcode < 4'd7;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = (op_valid && legal) ? FETCH_A : IDLE;
      FETCH_A: state_next = FETCH_B;
      FETCH_B: state_next = EXEC;
      EXEC:    state_next = WRITE;
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      opc        <= '0;
      ra         <= '0;
      rb         <= '0;
      rdq        <= '0;
      opa        <= '0;
      opb        <= '0;
      in1        <= '0;
      result     <= '0;
      carry_next <= 1'b0;
      err_q      <= 1'b0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      err_q <= state == IDLE && op_valid && !legal;
      if (state == IDLE && op_valid) begin
        opc <= opcode;
        ra  <= rs_a;
        rb  <= rs_b;
        rdq <= rd;
      end
      if (state == FETCH_A) opa <= rf_rdata;
      if (state == FETCH_B) begin
        opb <= rf_rdata;
        in1 <= opa;
      end
      if (state == EXEC) begin
        result     <= alu_out;
        carry_next <= alu_overflow;
      end
      if (state == WRITE) begin
        zero_flag  <= result == '0;
        carry_flag <= carry_next;
      end
    end
  // opb only changes on entry to EXEC, so it doubles as the held in2 value
  assign alu_in1  = in1;
  assign alu_in2  = opb;
  assign exec     = state == EXEC;
  assign alu_add  = exec && opc == 4'd0;
  assign alu_sub  = exec && opc == 4'd1;
  assign alu_and  = exec && opc == 4'd2;
  assign alu_or   = exec && opc == 4'd3;
  assign alu_xor  = exec && opc == 4'd4;
  assign alu_inv  = exec && opc == 4'd5;
  assign alu_clr  = exec && opc == 4'd6;
  assign op_ready = state == IDLE;
  assign rf_raddr = state == FETCH_A ? ra : state == FETCH_B ? rb : '0;
  assign rf_we    = state == WRITE;
  assign rf_waddr = rf_we ? rdq : '0;
  assign rf_wdata = rf_we ? result : '0;
  assign done     = rf_we || err_q;
  assign err      = err_q;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random operations against a register-level reference model
module tb_alu_op_sequencer;
  logic clk = 0, reset = 0, op_valid = 0;
  logic [3:0] opcode = 0;
  logic [1:0] rs_a = 0, rs_b = 0, rd = 0, rf_raddr, rf_waddr;
  logic [7:0] rf_rdata, rf_wdata, alu_in1, alu_in2, alu_out;
  logic op_ready, rf_we, done, err, zero_flag, carry_flag, alu_overflow;
  logic alu_add, alu_sub, alu_and, alu_or, alu_xor, alu_inv, alu_clr;
  logic [6:0] ctrl;
  logic [8:0] alu_sum;
  logic [7:0] rf [4];
  logic pre_we = 0;
  logic [1:0] pre_addr = 0;
  logic [7:0] pre_data = 0;
  logic [7:0] ref_rf [4];
  logic ref_z = 0, ref_c = 0;
  int n_cmp = 0, n_bad = 0;

  alu_op_sequencer #(.DATA_WIDTH(8), .ADDR_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready), .opcode(opcode),
    .rs_a(rs_a), .rs_b(rs_b), .rd(rd), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_add(alu_add), .alu_sub(alu_sub), .alu_and(alu_and), .alu_or(alu_or), .alu_xor(alu_xor),
    .alu_inv(alu_inv), .alu_clr(alu_clr), .alu_out(alu_out), .alu_overflow(alu_overflow),
    .done(done), .err(err), .zero_flag(zero_flag), .carry_flag(carry_flag));

  always #5 clk = ~clk;
  assign ctrl = {alu_clr, alu_inv, alu_xor, alu_or, alu_and, alu_sub, alu_add};
  assign rf_rdata = rf[rf_raddr];
  always @(posedge clk)
    if (rf_we) rf[rf_waddr] <= rf_wdata;
    else if (pre_we) rf[pre_addr] <= pre_data;

  // stand-in ALU: carry out of ADD, borrow out of SUB
  always_comb begin
    alu_sum = 9'd0;
    if (alu_add) alu_sum = {1'b0, alu_in1} + {1'b0, alu_in2};
    else if (alu_sub) alu_sum = {1'b0, alu_in1} - {1'b0, alu_in2};
    else if (alu_and) alu_sum = {1'b0, alu_in1 & alu_in2};
    else if (alu_or) alu_sum = {1'b0, alu_in1 | alu_in2};
    else if (alu_xor) alu_sum = {1'b0, alu_in1 ^ alu_in2};
    else if (alu_inv) alu_sum = {1'b0, ~alu_in1};
  end
  assign alu_out = alu_sum[7:0];
  assign alu_overflow = alu_sum[8];

  task automatic set_reg(input logic [1:0] i, input logic [7:0] v);
    pre_we = 1; pre_addr = i; pre_data = v;
    @(negedge clk);
    pre_we = 0;
    ref_rf[i] = v;
  endtask

  task automatic run_op(input logic [3:0] oc, input logic [1:0] a, b, d, input bit hold);
    logic [7:0] x, y, r;
    logic c;
    logic [6:0] hot;
    x = ref_rf[a]; y = ref_rf[b]; c = 0; r = 0;
    case (oc)
      0: {c, r} = {1'b0, x} + {1'b0, y};
      1: {c, r} = {1'b0, x} - {1'b0, y};
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = ~x;
      default: r = 0;
    endcase
    hot = 7'd1 << oc;
    n_cmp++; if (op_ready !== 1'b1) begin n_bad++; $display("FAIL ready_before: got %b expected 1", op_ready); end
    op_valid = 1; opcode = oc; rs_a = a; rs_b = b; rd = d;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_cmp++; if (op_ready !== 1'b0) begin n_bad++; $display("FAIL busy_ready c%0d: got %b expected 0", k, op_ready); end
      n_cmp++; if ({rf_we, done, err} !== (k == 4 ? 3'b110 : 3'b000)) begin n_bad++; $display("FAIL we_done_err c%0d: got %b expected %b", k, {rf_we, done, err}, (k == 4 ? 3'b110 : 3'b000)); end
      n_cmp++; if (ctrl !== (k == 3 ? hot : 7'd0)) begin n_bad++; $display("FAIL ctrl c%0d op%0d: got %b expected %b", k, oc, ctrl, (k == 3 ? hot : 7'd0)); end
      n_cmp++; if (rf_raddr !== (k == 1 ? a : k == 2 ? b : 2'd0)) begin n_bad++; $display("FAIL raddr c%0d: got %0d expected %0d", k, rf_raddr, (k == 1 ? a : k == 2 ? b : 2'd0)); end
      if (k >= 3) begin
        n_cmp++; if ({alu_in1, alu_in2} !== {x, y}) begin n_bad++; $display("FAIL operands c%0d: got %h/%h expected %h/%h", k, alu_in1, alu_in2, x, y); end
      end
      if (k == 4) begin
        n_cmp++; if ({rf_waddr, rf_wdata} !== {d, r}) begin n_bad++; $display("FAIL write op%0d: got R%0d=%h expected R%0d=%h", oc, rf_waddr, rf_wdata, d, r); end
      end
      op_valid = hold ? 1'b1 : (k < 4 ? 1'($urandom) : 1'b0);
      opcode = 4'($urandom); rs_a = 2'($urandom); rs_b = 2'($urandom); rd = 2'($urandom);
    end
    ref_rf[d] = r; ref_z = r == 0; ref_c = c;
    @(negedge clk);
    n_cmp++; if ({op_ready, done, rf_we} !== 3'b100) begin n_bad++; $display("FAIL after_op ready/done/we: got %b expected 100", {op_ready, done, rf_we}); end
    n_cmp++; if ({zero_flag, carry_flag} !== {ref_z, ref_c}) begin n_bad++; $display("FAIL flags op%0d: got z%b c%b expected z%b c%b", oc, zero_flag, carry_flag, ref_z, ref_c); end
    n_cmp++; if (rf[d] !== r) begin n_bad++; $display("FAIL rf_content R%0d: got %h expected %h", d, rf[d], r); end
  endtask

  task automatic test_reset;
    reset = 0;
    repeat (3) @(negedge clk);
    n_cmp++; if ({op_ready, rf_we, done, err} !== 4'b1000) begin n_bad++; $display("FAIL reset_ctl: got %b expected 1000", {op_ready, rf_we, done, err}); end
    reset = 1; ref_z = 0; ref_c = 0;
    @(negedge clk);
    n_cmp++; if ({op_ready, rf_we, done, err} !== 4'b1000) begin n_bad++; $display("FAIL reset_release_ctl: got %b expected 1000", {op_ready, rf_we, done, err}); end
    n_cmp++; if (ctrl !== 7'd0) begin n_bad++; $display("FAIL reset_alu_ctrl: got %b expected 0", ctrl); end
    n_cmp++; if ({zero_flag, carry_flag} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b expected 00", {zero_flag, carry_flag}); end
    n_cmp++; if ({alu_in1, alu_in2, rf_raddr, rf_waddr, rf_wdata} !== 28'd0) begin n_bad++; $display("FAIL reset_buses: got %h expected 0", {alu_in1, alu_in2, rf_raddr, rf_waddr, rf_wdata}); end
  endtask

  task automatic test_add;
    set_reg(1, 8'h30); set_reg(2, 8'h25);
    run_op(0, 1, 2, 3, 0);
  endtask

  task automatic test_sub_carry;
    set_reg(1, 8'h05); set_reg(2, 8'h05);
    run_op(1, 1, 2, 0, 0);
    set_reg(1, 8'hF0); set_reg(2, 8'h20);
    run_op(0, 1, 2, 3, 0);
  endtask

  task automatic test_illegal(input logic [3:0] oc);
    op_valid = 1; opcode = oc; rs_a = 2'($urandom); rs_b = 2'($urandom); rd = 2'($urandom);
    @(negedge clk);
    op_valid = 0;
    n_cmp++; if ({done, err, rf_we, op_ready} !== 4'b1101) begin n_bad++; $display("FAIL illegal%0d_pulse: got %b expected 1101", oc, {done, err, rf_we, op_ready}); end
    n_cmp++; if (ctrl !== 7'd0) begin n_bad++; $display("FAIL illegal%0d_ctrl: got %b expected 0", oc, ctrl); end
    @(negedge clk);
    n_cmp++; if ({done, err, rf_we, op_ready} !== 4'b0001) begin n_bad++; $display("FAIL illegal%0d_after: got %b expected 0001", oc, {done, err, rf_we, op_ready}); end
    n_cmp++; if ({zero_flag, carry_flag} !== {ref_z, ref_c}) begin n_bad++; $display("FAIL illegal%0d_flags: got %b expected %b", oc, {zero_flag, carry_flag}, {ref_z, ref_c}); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] old;
    set_reg(0, 8'h3C); set_reg(1, 8'hA5);
    old = ref_rf[2];
    op_valid = 1; opcode = 4; rs_a = 0; rs_b = 1; rd = 2;
    repeat (3) begin
      @(negedge clk);
      op_valid = 0;
    end
    n_cmp++; if (alu_xor !== 1'b1) begin n_bad++; $display("FAIL mid_xor_exec: got %b expected 1", alu_xor); end
    reset = 0; ref_z = 0; ref_c = 0;
    #1;
    n_cmp++; if ({op_ready, done, rf_we, ctrl} !== {3'b100, 7'd0}) begin n_bad++; $display("FAIL mid_reset_abort: got %b expected %b", {op_ready, done, rf_we, ctrl}, {3'b100, 7'd0}); end
    n_cmp++; if ({zero_flag, carry_flag} !== 2'b00) begin n_bad++; $display("FAIL mid_reset_flags: got %b expected 00", {zero_flag, carry_flag}); end
    repeat (2) @(negedge clk);
    reset = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_cmp++; if ({rf_we, done, alu_xor} !== 3'b000) begin n_bad++; $display("FAIL mid_reset_quiet c%0d: got %b expected 000", k, {rf_we, done, alu_xor}); end
    end
    n_cmp++; if (rf[2] !== old) begin n_bad++; $display("FAIL mid_reset_nowrite: got %h expected %h", rf[2], old); end
    run_op(4, 0, 1, 2, 0);
  endtask

  task automatic test_back_to_back;
    set_reg(1, 8'h0C); set_reg(2, 8'h0A);
    run_op(2, 1, 2, 1, 1);
    run_op(4, 1, 2, 0, 0);
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(7) == 0) test_illegal(4'($urandom_range(15, 7)));
      else run_op(4'($urandom_range(6)), 2'($urandom), 2'($urandom), 2'($urandom), i < n - 1 && $urandom_range(1) == 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset;
    for (int i = 0; i < 4; i++) set_reg(2'(i), 8'($urandom));
    test_add;
    test_sub_carry;
    test_illegal(9);
    test_reset_mid;
    test_back_to_back;
    test_random(40);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
